// File: rtl/timer_alarm.sv
// Timer expiry alarm: latches an interrupt on the rising edge of timer_out and plays a fixed beep pattern.
// Optional expiry counter is built only when TIMER_ALARM_COUNT_EN is defined; otherwise event_count is 0.
module timer_alarm #(
    parameter int BEEP_ON  = 4,
    parameter int BEEP_OFF = 2,
    parameter int BEEP_CNT = 3,
    parameter int CNT_W    = 8
) (
    input  logic             timer_clock,
    input  logic             timer_rstn,
    input  logic             timer_out,
    input  logic             alarm_ack,
    output logic             alarm_irq,
    output logic             buzzer,
    output logic             alarm_busy,
    output logic [CNT_W-1:0] event_count
);

    localparam int PH_MAX = (BEEP_ON > BEEP_OFF) ? BEEP_ON : BEEP_OFF;
    localparam int PH_W   = ($clog2(PH_MAX) < 1) ? 1 : $clog2(PH_MAX);
    localparam int BC_W   = ($clog2(BEEP_CNT) < 1) ? 1 : $clog2(BEEP_CNT);

    localparam logic [PH_W-1:0] ON_LAST  = PH_W'(BEEP_ON - 1);
    localparam logic [PH_W-1:0] OFF_LAST = PH_W'(BEEP_OFF - 1);
    localparam logic [BC_W-1:0] CNT_LAST = BC_W'(BEEP_CNT - 1);

    typedef enum logic [1:0] {IDLE, ON, OFF, HOLD} state_e;

    state_e          state_q, state_d;
    logic [PH_W-1:0] phase_q, phase_d;
    logic [BC_W-1:0] beep_q, beep_d;
    logic            irq_q, irq_d;
    logic            tout_q;
    logic            rise;

    assign rise = timer_out & ~tout_q;

    always_ff @(posedge timer_clock or negedge timer_rstn) begin
        if (!timer_rstn) begin
            state_q <= IDLE;
            phase_q <= '0;
            beep_q  <= '0;
            irq_q   <= 1'b0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            beep_q  <= beep_d;
            irq_q   <= irq_d;
            tout_q  <= timer_out;
        end
    end

    // A rise restarts the pattern from any state and takes priority over ack.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        beep_d  = beep_q;
        irq_d   = irq_q;
        if (rise) begin
            state_d = ON;
            phase_d = '0;
            beep_d  = '0;
            irq_d   = 1'b1;
        end else begin
            case (state_q)
                IDLE: ;
                ON: begin
                    if (alarm_ack) begin
                        state_d = IDLE;
                        irq_d   = 1'b0;
                    end else if (phase_q == ON_LAST) begin
                        state_d = OFF;
                        phase_d = '0;
                    end else begin
                        phase_d = phase_q + 1'b1;
                    end
                end
                OFF: begin
                    if (alarm_ack) begin
                        state_d = IDLE;
                        irq_d   = 1'b0;
                    end else if (phase_q == OFF_LAST) begin
                        if (beep_q == CNT_LAST) begin
                            state_d = HOLD;
                        end else begin
                            state_d = ON;
                            beep_d  = beep_q + 1'b1;
                            phase_d = '0;
                        end
                    end else begin
                        phase_d = phase_q + 1'b1;
                    end
                end
                HOLD: begin
                    if (alarm_ack) begin
                        state_d = IDLE;
                        irq_d   = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign alarm_irq  = irq_q;
    assign buzzer     = (state_q == ON);
    assign alarm_busy = (state_q != IDLE);

`ifdef TIMER_ALARM_COUNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge timer_clock or negedge timer_rstn) begin
        if (!timer_rstn)                 cnt_q <= '0;
        else if (rise && (cnt_q != '1))  cnt_q <= cnt_q + 1'b1;
    end

    assign event_count = cnt_q;
`else
    assign event_count = '0;
`endif

endmodule

// File: tb/tb_timer_alarm.sv
// Self-checking bench for timer_alarm: directed scenarios plus random traffic against a
// cycle-offset model of the beep pattern.
module tb_timer_alarm;

    localparam int BEEP_ON  = 4;
    localparam int BEEP_OFF = 2;
    localparam int BEEP_CNT = 3;
    localparam int PER      = BEEP_ON + BEEP_OFF;
    localparam int PAT      = BEEP_CNT * PER;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       tout = 1'b0;
    logic       ack = 1'b0;
    logic       irq, buz, busy;
    logic [7:0] cnt;
    logic       irq2, buz2, busy2;
    logic [1:0] cnt2;

    int checks = 0;
    int errors = 0;

    // Model: offset into the pattern since the last restart.
    bit m_act, m_irq, m_prev;
    int m_t, m_cnt, m_cnt2;

    always #5 clk = ~clk;

    timer_alarm #(.BEEP_ON(BEEP_ON), .BEEP_OFF(BEEP_OFF), .BEEP_CNT(BEEP_CNT), .CNT_W(8)) dut (
        .timer_clock(clk), .timer_rstn(rstn), .timer_out(tout), .alarm_ack(ack),
        .alarm_irq(irq), .buzzer(buz), .alarm_busy(busy), .event_count(cnt)
    );

    timer_alarm #(.BEEP_ON(BEEP_ON), .BEEP_OFF(BEEP_OFF), .BEEP_CNT(BEEP_CNT), .CNT_W(2)) dut2 (
        .timer_clock(clk), .timer_rstn(rstn), .timer_out(tout), .alarm_ack(ack),
        .alarm_irq(irq2), .buzzer(buz2), .alarm_busy(busy2), .event_count(cnt2)
    );

    function automatic bit m_buz();
        return m_act && (m_t < PAT) && ((m_t % PER) < BEEP_ON);
    endfunction

    function automatic int exp_cnt(input int c);
`ifdef TIMER_ALARM_COUNT_EN
        return c;
`else
        return 0;
`endif
    endfunction

    function automatic logic [2:0] m_outs();
        return {m_irq, m_buz(), m_act};
    endfunction

    task automatic model_reset();
        m_act = 0; m_irq = 0; m_prev = 0; m_t = 0; m_cnt = 0; m_cnt2 = 0;
    endtask

    // Drive one cycle of inputs, advance one edge, update the model, settle 1 time unit.
    task automatic tick(input logic t, input logic a);
        bit r;
        tout = t;
        ack  = a;
        @(posedge clk);
        r = t && !m_prev;
        m_prev = t;
        if (r) begin
            m_act = 1; m_irq = 1; m_t = 0;
            if (m_cnt < 255) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
        end else if (a && m_act) begin
            m_act = 0; m_irq = 0;
        end else if (m_act && m_t < PAT) begin
            m_t++;
        end
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0; tout = 1'b0; ack = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk) rstn = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; tout = 1'b0; ack = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({irq, buz, busy, cnt} !== 11'b0) begin
            errors++; $display("FAIL reset_outs got=%b want=0", {irq, buz, busy, cnt});
        end
        tout = 1'b1; ack = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({irq, buz, busy, cnt, cnt2} !== 13'b0) begin
            errors++; $display("FAIL reset_hold got=%b want=0", {irq, buz, busy, cnt, cnt2});
        end
        // Releasing reset with timer_out high yields a rise on the first edge.
        ack = 1'b0;
        @(negedge clk) rstn = 1'b1;
        tick(1'b1, 1'b0);
        checks++;
        if ({irq, buz, busy} !== 3'b111 || cnt !== 8'(exp_cnt(1))) begin
            errors++; $display("FAIL reset_release_rise got=%b cnt=%0d want=111 cnt=%0d",
                               {irq, buz, busy}, cnt, exp_cnt(1));
        end
    endtask

    task automatic test_full_pattern();
        bit want_buz;
        do_reset();
        for (int e = 1; e <= 10; e++) tick(1'b0, 1'b0);
        for (int e = 11; e <= 34; e++) begin
            tick(1'b1, 1'b0);
            want_buz = (e >= 11 && e <= 14) || (e >= 17 && e <= 20) || (e >= 23 && e <= 26);
            checks++;
            if ({irq, buz, busy} !== {1'b1, want_buz, 1'b1} || {irq, buz, busy} !== m_outs()) begin
                errors++; $display("FAIL full_pattern edge=%0d got=%b want=%b", e, {irq, buz, busy}, m_outs());
            end
        end
        tick(1'b1, 1'b1);
        checks++;
        if ({irq, buz, busy} !== 3'b000 || cnt !== 8'(exp_cnt(1))) begin
            errors++; $display("FAIL full_pattern_ack got=%b cnt=%0d want=000 cnt=%0d",
                               {irq, buz, busy}, cnt, exp_cnt(1));
        end
    endtask

    task automatic test_early_ack();
        do_reset();
        for (int e = 1; e <= 10; e++) tick(1'b0, 1'b0);
        for (int e = 11; e <= 17; e++) tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);
        checks++;
        if ({irq, buz, busy} !== 3'b000) begin
            errors++; $display("FAIL early_ack got=%b want=000", {irq, buz, busy});
        end
        for (int i = 0; i < 30; i++) tick(1'b1, 1'b0);
        checks++;
        if ({irq, buz, busy} !== 3'b000 || cnt !== 8'(exp_cnt(1))) begin
            errors++; $display("FAIL early_ack_held got=%b cnt=%0d want=000 cnt=%0d",
                               {irq, buz, busy}, cnt, exp_cnt(1));
        end
    endtask

    task automatic test_retrigger();
        do_reset();
        for (int e = 1; e <= 10; e++) tick(1'b0, 1'b0);
        for (int e = 11; e <= 14; e++) tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        checks++;
        if ({irq, buz, busy} !== 3'b101) begin
            errors++; $display("FAIL retrigger_off got=%b want=101", {irq, buz, busy});
        end
        for (int e = 16; e <= 21; e++) begin
            tick(1'b1, 1'b0);
            checks++;
            if (buz !== (e <= 19) || {irq, buz, busy} !== m_outs()) begin
                errors++; $display("FAIL retrigger edge=%0d got=%b want=%b", e, {irq, buz, busy}, m_outs());
            end
        end
        checks++;
        if (cnt !== 8'(exp_cnt(2))) begin
            errors++; $display("FAIL retrigger_count got=%0d want=%0d", cnt, exp_cnt(2));
        end
    endtask

    task automatic test_ack_rise();
        do_reset();
        tick(1'b1, 1'b0);
        for (int i = 0; i < 7; i++) tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b1);
        checks++;
        if ({irq, buz, busy} !== 3'b111 || cnt !== 8'(exp_cnt(2))) begin
            errors++; $display("FAIL ack_rise got=%b cnt=%0d want=111 cnt=%0d",
                               {irq, buz, busy}, cnt, exp_cnt(2));
        end
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b0);
        checks++;
        if ({irq, buz, busy} !== m_outs()) begin
            errors++; $display("FAIL ack_rise_pattern got=%b want=%b", {irq, buz, busy}, m_outs());
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        #2 rstn = 1'b0;
        #1;
        checks++;
        if ({irq, buz, busy, cnt} !== 11'b0) begin
            errors++; $display("FAIL async_reset got=%b want=0", {irq, buz, busy, cnt});
        end
        model_reset();
        tout = 1'b0;
        @(negedge clk) rstn = 1'b1;
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 1'b0);
            tick(1'b1, 1'b0);
        end
        checks++;
        if (cnt2 !== 2'(exp_cnt(3)) || cnt2 !== 2'(exp_cnt(m_cnt2))) begin
            errors++; $display("FAIL saturation got=%0d want=%0d", cnt2, exp_cnt(3));
        end
        checks++;
        if (cnt !== 8'(exp_cnt(5))) begin
            errors++; $display("FAIL saturation_wide got=%0d want=%0d", cnt, exp_cnt(5));
        end
    endtask

    task automatic test_random();
        logic t = 1'b0;
        logic a;
        do_reset();
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 7) == 0) t = ~t;
            a = ($urandom_range(0, 11) == 0);
            tick(t, a);
            checks++;
            if ({irq, buz, busy} !== m_outs() || cnt !== 8'(exp_cnt(m_cnt)) ||
                cnt2 !== 2'(exp_cnt(m_cnt2))) begin
                errors++; $display("FAIL random cyc=%0d got=%b cnt=%0d/%0d want=%b cnt=%0d/%0d", i,
                                   {irq, buz, busy}, cnt, cnt2, m_outs(), exp_cnt(m_cnt), exp_cnt(m_cnt2));
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_pattern();
        test_early_ack();
        test_retrigger();
        test_ack_rise();
        test_async_reset();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
